// File: rtl/eth_bridge_pkg.sv
// rtl/eth_bridge_pkg.sv - shared types and widths for the Ethernet bridge TX path
package eth_bridge_pkg;

  localparam int NUM_REQ = 2;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick, one-hot grant
module rr_arbiter2
  import eth_bridge_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_served,
  output logic [NUM_REQ-1:0] gnt
);

  // On contention favour the port that was not served last; otherwise pass the lone request
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_served ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - frame-granular round-robin scheduler feeding one TX MAC
module tx_frame_arbiter
  import eth_bridge_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_FRAME  = 1518
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_frame_rdy,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_rd_en,
  output logic [BYTE_W-1:0]         tx_mac_data,
  output logic                      tx_mac_valid,
  output logic                      tx_mac_last,
  input  logic                      tx_mac_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      err_oversize
);

  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [10:0] MAX_M1   = 11'(MAX_FRAME - 1);
  localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [10:0]        byte_cnt;
  logic [7:0]         gap_cnt;
  logic               last_served;
  logic [NUM_REQ-1:0] pick;
  logic               sel;
  logic               head_last;
  logic               hs;
  logic               at_max;
  logic [BYTE_W-1:0]  head_data;

  rr_arbiter2 u_rr (
    .req         (req_frame_rdy),
    .last_served (last_served),
    .gnt         (pick)
  );

  // The granted buffer's head byte; grant is one-hot so its upper bit is the port index
  assign sel       = grant[1];
  assign head_data = sel ? req_data[2*BYTE_W-1:BYTE_W] : req_data[BYTE_W-1:0];
  assign head_last = req_last[sel];
  assign hs        = tx_mac_valid & tx_mac_ready;
  // Current byte would be number MAX_FRAME of the frame
  assign at_max    = (byte_cnt == MAX_M1);

  // Next-state decode and the combinational pop/data path
  always_comb begin
    state_next  = state;
    req_rd_en   = '0;
    tx_mac_data = '0;
    tx_mac_last = 1'b0;
    case (state)
      IDLE: begin
        if (|req_frame_rdy) state_next = SEND;
      end
      SEND: begin
        tx_mac_data = head_data;
        tx_mac_last = head_last | at_max;
        req_rd_en   = grant & {NUM_REQ{hs}};
        if (hs) begin
          if (head_last)   state_next = GAP;
          else if (at_max) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Discard the rest of an oversize frame, including its last byte
        req_rd_en = grant;
        if (head_last) state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == 8'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the registered status outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tx_mac_valid <= 1'b0;
      busy         <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_next;
      tx_mac_valid <= (state_next == SEND);
      busy         <= (state_next != IDLE);
      err_oversize <= (state == SEND) && (state_next == DRAIN);
    end
  end

  // Grant is latched at frame start and held through SEND, DRAIN and GAP
  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= '0;
    end else if (state == IDLE && state_next == SEND) begin
      grant <= pick;
    end else if (state_next == IDLE) begin
      grant <= '0;
    end
  end

  // Round-robin history changes only when a frame completes normally
  always_ff @(posedge clk) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (state == SEND && hs && head_last) begin
      last_served <= sel;
    end
  end

  // Per-frame byte counter, saturating at the frame limit
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      byte_cnt <= '0;
    end else if (hs && byte_cnt != MAX_CNT) begin
      byte_cnt <= byte_cnt + 11'd1;
    end
  end

  // Inter-frame gap counter: loaded on entry to GAP, counts down while there
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state != GAP && state_next == GAP) begin
      gap_cnt <= IFG_LOAD;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - scoreboard bench for tx_frame_arbiter
module tb_tx_frame_arbiter;

  localparam int IFG  = 12;
  localparam int MAXF = 64;

  logic        clk;
  logic        reset;
  logic [1:0]  req_frame_rdy;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_rd_en;
  logic [7:0]  tx_mac_data;
  logic        tx_mac_valid;
  logic        tx_mac_last;
  logic        tx_mac_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        err_oversize;

  tx_frame_arbiter #(.IFG_CYCLES(IFG), .MAX_FRAME(MAXF)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_frame_rdy (req_frame_rdy),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_rd_en     (req_rd_en),
    .tx_mac_data   (tx_mac_data),
    .tx_mac_valid  (tx_mac_valid),
    .tx_mac_last   (tx_mac_last),
    .tx_mac_ready  (tx_mac_ready),
    .grant         (grant),
    .busy          (busy),
    .err_oversize  (err_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        port;
    logic        trunc;
    logic        gap_chk;
    logic [15:0] tail;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] b0_d[$];
  logic [7:0] b1_d[$];
  logic       b0_l[$];
  logic       b1_l[$];
  logic [7:0] m0_d[$];
  logic [7:0] m1_d[$];
  int         m0_n[$];
  int         m1_n[$];

  int          nfr0, nfr1, pops, hs_cnt, checks, failures;
  int          ready_mode, pat_i, since_last;
  bit          mon_en, in_frame, err_pend;
  logic [1:0]  rd_s;
  logic        m_last;
  logic [15:0] prev_tail;
  logic [3:0]  pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req_frame_rdy  = {nfr1 > 0, nfr0 > 0};
    req_data[7:0]  = (b0_d.size() > 0) ? b0_d[0] : 8'h00;
    req_data[15:8] = (b1_d.size() > 0) ? b1_d[0] : 8'h00;
    req_last[0]    = (b0_l.size() > 0) ? b0_l[0] : 1'b0;
    req_last[1]    = (b1_l.size() > 0) ? b1_l[0] : 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rd_s[0]) begin
      chk("pop0_nonempty", 32'(b0_d.size() != 0), 32'd1);
      if (b0_d.size() != 0) begin
        void'(b0_d.pop_front());
        if (b0_l.pop_front()) nfr0--;
        pops++;
      end
    end
    if (rd_s[1]) begin
      chk("pop1_nonempty", 32'(b1_d.size() != 0), 32'd1);
      if (b1_d.size() != 0) begin
        void'(b1_d.pop_front());
        if (b1_l.pop_front()) nfr1--;
        pops++;
      end
    end
    case (ready_mode)
      1: tx_mac_ready = 1'b1;
      2: begin tx_mac_ready = pat[pat_i % 4]; pat_i++; end
      default: tx_mac_ready = ($urandom_range(0, 3) != 0);
    endcase
    drive();
  endtask

  task automatic load_frame(input int p, input int len, input bit ramp);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = ramp ? 8'(k) : 8'($urandom_range(0, 255));
      if (p == 0) begin b0_d.push_back(d); b0_l.push_back(k == len - 1); m0_d.push_back(d); end
      else        begin b1_d.push_back(d); b1_l.push_back(k == len - 1); m1_d.push_back(d); end
    end
    if (p == 0) begin m0_n.push_back(len); nfr0++; end
    else        begin m1_n.push_back(len); nfr1++; end
  endtask

  // Reference: all loaded frames are complete, so service order follows the round-robin rule
  task automatic build_expected();
    bit         first;
    int         p, len, sent;
    logic [7:0] d;
    exp_t       e;
    first = 1'b1;
    while (m0_n.size() + m1_n.size() > 0) begin
      if (m0_n.size() > 0 && m1_n.size() > 0) p = (m_last == 1'b1) ? 0 : 1;
      else p = (m0_n.size() > 0) ? 0 : 1;
      len  = (p == 0) ? m0_n.pop_front() : m1_n.pop_front();
      sent = (len > MAXF) ? MAXF : len;
      for (int k = 0; k < len; k++) begin
        d = (p == 0) ? m0_d.pop_front() : m1_d.pop_front();
        if (k < sent) begin
          e.data    = d;
          e.last    = (k == sent - 1);
          e.port    = 1'(p);
          e.trunc   = (len > MAXF);
          e.gap_chk = (k == 0) && !first;
          e.tail    = 16'(((len > MAXF) ? len - MAXF : 0) + IFG + 1);
          expq.push_back(e);
        end
      end
      if (len <= MAXF) m_last = 1'(p);
      first = 1'b0;
    end
  endtask

  task automatic finish_round(input int total);
    bit done;
    drive();
    build_expected();
    done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (expq.size() == 0 && !busy && nfr0 == 0 && nfr1 == 0 &&
          b0_d.size() == 0 && b1_d.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("round_done", 32'(done), 32'd1);
    chk("pop_count", pops, total);
  endtask

  // Monitor: compares every presented byte with the scoreboard and watches timing
  always @(negedge clk) begin
    exp_t e;
    rd_s = req_rd_en;
    if (!mon_en) begin
      in_frame   = 1'b0;
      since_last = -1;
      err_pend   = 1'b0;
    end else begin
      if (since_last >= 0) since_last++;
      chk("err_oversize", 32'(err_oversize), 32'(err_pend));
      err_pend = 1'b0;
      chk("rd_en_foreign", 32'(req_rd_en & ~grant), 32'd0);
      if (since_last > 0 && since_last == int'(prev_tail))
        chk("busy_low_after_gap", 32'(busy), 32'd0);
      else if (since_last > 0 && since_last == int'(prev_tail) - 1)
        chk("busy_held_in_gap", 32'(busy), 32'd1);
      if (tx_mac_valid) begin
        chk("busy_with_valid", 32'(busy), 32'd1);
        if (expq.size() == 0) begin
          chk("spurious_valid", 32'(tx_mac_valid), 32'd0);
        end else begin
          e = expq[0];
          chk("grant", 32'(grant), e.port ? 32'd2 : 32'd1);
          if (!in_frame) begin
            in_frame = 1'b1;
            if (e.gap_chk) chk("ifg_gap", since_last, 32'(prev_tail) + 32'd1);
          end
          if (tx_mac_ready) begin
            void'(expq.pop_front());
            hs_cnt++;
            chk("tx_data", 32'(tx_mac_data), 32'(e.data));
            chk("tx_last", 32'(tx_mac_last), 32'(e.last));
            chk("rd_en_hs", 32'(req_rd_en), 32'(grant));
            if (e.last) begin
              in_frame   = 1'b0;
              since_last = 0;
              prev_tail  = e.tail;
              err_pend   = e.trunc;
            end
          end else begin
            chk("rd_en_stall", 32'(req_rd_en), 32'd0);
          end
        end
      end
    end
  end

  task automatic check_all_zero();
    chk("rst_valid", 32'(tx_mac_valid), 32'd0);
    chk("rst_last", 32'(tx_mac_last), 32'd0);
    chk("rst_data", 32'(tx_mac_data), 32'd0);
    chk("rst_rd_en", 32'(req_rd_en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_oversize), 32'd0);
  endtask

  initial begin
    int  tot, n0, n1, len;
    bit  reached;
    checks = 0; failures = 0; nfr0 = 0; nfr1 = 0; pops = 0; hs_cnt = 0;
    ready_mode = 1; pat_i = 0; pat = 4'b1001; since_last = -1; prev_tail = '0;
    mon_en = 1'b0; in_frame = 1'b0; err_pend = 1'b0; rd_s = '0; m_last = 1'b1;
    reset = 1'b1; tx_mac_ready = 1'b0; req_frame_rdy = '0; req_data = '0; req_last = '0;
    repeat (3) step();
    check_all_zero();
    reset = 1'b0;
    mon_en = 1'b1;

    // Both ports with three frames each: strict alternation starting at port 0
    pops = 0; ready_mode = 1; tot = 0;
    for (int k = 0; k < 3; k++) begin
      len = int'($urandom_range(8, MAXF)); load_frame(0, len, 1'b0); tot += len;
      len = int'($urandom_range(8, MAXF)); load_frame(1, len, 1'b0); tot += len;
    end
    finish_round(tot);

    // Port 0 alone, 64-byte ramp
    pops = 0; ready_mode = 1;
    load_frame(0, 64, 1'b1);
    finish_round(64);

    // Stalled 10-byte frame on port 1
    pops = 0; ready_mode = 2; pat_i = 0;
    load_frame(1, 10, 1'b0);
    finish_round(10);

    // Oversize frame followed by a normal frame from the same buffer
    pops = 0; ready_mode = 1;
    load_frame(0, 70, 1'b1);
    load_frame(0, 20, 1'b0);
    finish_round(90);

    // Boundary lengths around the limit, random backpressure
    pops = 0; ready_mode = 0;
    load_frame(0, MAXF, 1'b0);
    load_frame(1, MAXF + 1, 1'b0);
    load_frame(0, 1, 1'b0);
    finish_round(2 * MAXF + 2);

    // Reset in the middle of a frame
    pops = 0; ready_mode = 1; hs_cnt = 0;
    load_frame(0, 99, 1'b1);
    load_frame(1, 30, 1'b0);
    drive();
    build_expected();
    reached = 1'b0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (hs_cnt >= 20) begin reached = 1'b1; break; end
    end
    chk("reach_byte20", 32'(reached), 32'd1);
    reset = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero();
    b0_d.delete(); b1_d.delete(); b0_l.delete(); b1_l.delete();
    m0_d.delete(); m1_d.delete(); m0_n.delete(); m1_n.delete(); expq.delete();
    nfr0 = 0; nfr1 = 0; m_last = 1'b1;
    reset = 1'b0;
    mon_en = 1'b1;
    pops = 0;
    load_frame(0, 20, 1'b0);
    load_frame(1, 20, 1'b0);
    finish_round(40);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      pops = 0; ready_mode = 0; tot = 0;
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range((n0 == 0) ? 1 : 0, 3));
      for (int k = 0; k < n0 + n1; k++) begin
        len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MAXF + 1, MAXF + 10))
                                          : int'($urandom_range(1, MAXF));
        load_frame((k < n0) ? 0 : 1, len, 1'b0);
        tot += len;
      end
      finish_round(tot);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
